// File: rtl/inst_sequencer.sv
// Instruction sequencer: fetch / decode / execute / memory / writeback control FSM
// with per-state wait timeout, sticky fault state and a retired-instruction counter.
module inst_sequencer #(
    parameter logic [31:0] PC_RESET    = 32'h0000_0000,
    parameter int unsigned MEM_TIMEOUT = 15
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        run_i,
    input  logic [31:0] inst_i,
    input  logic        imem_ack_i,
    input  logic        dmem_ack_i,
    input  logic        branch_inst_i,
    input  logic        data_inst_i,
    input  logic        load_inst_i,
    input  logic        write_en_i,
    input  logic        cond_execute_i,
    output logic        imem_req_o,
    output logic [31:0] pc_o,
    output logic [31:0] ir_o,
    output logic        alu_en_o,
    output logic        dmem_req_o,
    output logic        reg_we_o,
    output logic [15:0] retired_o,
    output logic [2:0]  state_o,
    output logic        fault_o
);

    localparam logic [2:0] StIdle   = 3'd0;
    localparam logic [2:0] StFetch  = 3'd1;
    localparam logic [2:0] StDecode = 3'd2;
    localparam logic [2:0] StExec   = 3'd3;
    localparam logic [2:0] StMem    = 3'd4;
    localparam logic [2:0] StWb     = 3'd5;
    localparam logic [2:0] StFault  = 3'd6;

    // Last waiting cycle: an ack here still wins, otherwise the wait expires.
    localparam logic [3:0] WaitLast = 4'(MEM_TIMEOUT - 1);

    logic [2:0]  state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] ir_q, ir_d;
    logic [15:0] ret_q, ret_d;
    logic [3:0]  cnt_q, cnt_d;
    // Blocks the first IDLE->FETCH until one full clock after reset release.
    logic        arm_q;

    logic        flags_legal;
    logic [2:0]  retire_state;
    logic [31:0] branch_target;

    assign retire_state  = run_i ? StFetch : StIdle;
    assign branch_target = pc_q + 32'd8 + {{6{ir_q[23]}}, ir_q[23:0], 2'b00};

    // Class flags must be exactly one-hot for a legal executed instruction.
    always_comb begin
        unique case ({branch_inst_i, data_inst_i, load_inst_i})
            3'b100, 3'b010, 3'b001: flags_legal = 1'b1;
            default:                flags_legal = 1'b0;
        endcase
    end

    // Next-state, architectural register updates and wait counter.
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        ir_d    = ir_q;
        ret_d   = ret_q;
        cnt_d   = 4'd0;
        case (state_q)
            StIdle: begin
                if (run_i && arm_q) state_d = StFetch;
            end
            StFetch: begin
                if (imem_ack_i) begin
                    ir_d    = inst_i;
                    state_d = StDecode;
                end else if (cnt_q == WaitLast) begin
                    state_d = StFault;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            StDecode: begin
                if (!cond_execute_i) begin
                    pc_d    = pc_q + 32'd4;
                    state_d = retire_state;
                end else if (!flags_legal) begin
                    state_d = StFault;
                end else if (load_inst_i) begin
                    state_d = StMem;
                end else begin
                    state_d = StExec;
                end
            end
            StExec: begin
                if (branch_inst_i) begin
                    pc_d    = branch_target;
                    ret_d   = ret_q + 16'd1;
                    state_d = retire_state;
                end else begin
                    state_d = StWb;
                end
            end
            StMem: begin
                if (dmem_ack_i) begin
                    state_d = StWb;
                end else if (cnt_q == WaitLast) begin
                    state_d = StFault;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            StWb: begin
                pc_d    = pc_q + 32'd4;
                ret_d   = ret_q + 16'd1;
                state_d = retire_state;
            end
            StFault: state_d = StFault;
            default: state_d = StFault;
        endcase
    end

    // State registers with asynchronous active-low reset.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= StIdle;
            pc_q    <= PC_RESET;
            ir_q    <= 32'd0;
            ret_q   <= 16'd0;
            cnt_q   <= 4'd0;
            arm_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            ir_q    <= ir_d;
            ret_q   <= ret_d;
            cnt_q   <= cnt_d;
            arm_q   <= 1'b1;
        end
    end

    // Moore strobes decoded from state only (reg_we also qualified by write_en).
    assign imem_req_o = (state_q == StFetch);
    assign alu_en_o   = (state_q == StExec);
    assign dmem_req_o = (state_q == StMem);
    assign reg_we_o   = (state_q == StWb) && write_en_i;
    assign fault_o    = (state_q == StFault);
    assign pc_o       = pc_q;
    assign ir_o       = ir_q;
    assign retired_o  = ret_q;
    assign state_o    = state_q;

endmodule
